iq_peak_hold: RTL and testbench

IQ_PEAK_HOLD -- requirements
Module: iq_peak_hold

---
 rtl/iq_peak_hold.sv | 235 +++++++++++++++++++++++
 tb/tb_iq_peak_hold.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/iq_peak_hold.sv
// iq_peak_hold: windowed peak-power (I^2+Q^2) detector on an interleaved IQ AXI-Stream.
// The input stream is forwarded unchanged one cycle later. When i_trigger is held high,
// the block measures a window of 2^g_WINDOW_LOG2 IQ pairs and reports the largest power
// seen in that window.
//
// Ports:
//   aclk, areset                 clock, synchronous active-high reset
//   s_axis_tdata/tvalid/tlast    input samples (tlast=0 is an I beat, tlast=1 is a Q beat)
//   m_axis_tdata/tvalid/tlast    input stream delayed by one cycle
//   i_trigger                    level enable for the measurement
//   o_peak_power                 peak I^2+Q^2 of the last completed window
//   o_peak_valid                 one-cycle pulse when o_peak_power updates
//   o_sync_err                   one-cycle pulse on a Q beat that has no held I
//   o_peak_index                 pair index of the peak (only when IQ_PEAK_HOLD_INDEX_EN is defined)
//
// Optional feature macro: IQ_PEAK_HOLD_INDEX_EN
module iq_peak_hold #(
    parameter int unsigned g_DATA_WIDTH  = 16,
    parameter int unsigned g_WINDOW_LOG2 = 8
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [g_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                      s_axis_tvalid,
    input  logic                      s_axis_tlast,
    output logic [g_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic                      m_axis_tvalid,
    output logic                      m_axis_tlast,
    input  logic                      i_trigger,
    output logic [2*g_DATA_WIDTH-1:0] o_peak_power,
    output logic                      o_peak_valid,
    output logic                      o_sync_err
`ifdef IQ_PEAK_HOLD_INDEX_EN
    ,
    output logic [g_WINDOW_LOG2-1:0]  o_peak_index
`endif
);

    localparam int unsigned DW = g_DATA_WIDTH;
    localparam int unsigned PW = 2 * g_DATA_WIDTH;
    localparam int unsigned CW = g_WINDOW_LOG2 + 1;
    localparam logic [CW-1:0] WIN_PAIRS = {1'b1, {g_WINDOW_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_REPORT  = 2'd2
    } state_t;

    // Passthrough registers
    logic [DW-1:0] m_tdata_q;
    logic          m_tvalid_q;
    logic          m_tlast_q;

    // Pair assembly
    logic                 i_held_q,   i_held_d;
    logic signed [DW-1:0] i_data_q,   i_data_d;
    logic                 sync_err_q, sync_err_d;

    // Power pipeline: products, then sum
    logic          prod_vld_q, prod_vld_d;
    logic [PW-1:0] prod_ii_q,  prod_ii_d;
    logic [PW-1:0] prod_qq_q,  prod_qq_d;
    logic          pwr_vld_q,  pwr_vld_d;
    logic [PW-1:0] pwr_q,      pwr_d;

    // Measurement FSM and its registers
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [PW-1:0] peak_q;
    logic [PW-1:0] peak_power_q;
    logic          peak_valid_q;

    logic                 pair_fire_c;
    logic signed [PW-1:0] i_ext_c;
    logic signed [PW-1:0] q_ext_c;
    logic [CW-1:0]        cnt_inc_c;
    logic                 new_peak_c;
    logic [PW-1:0]        peak_nxt_c;

`ifdef IQ_PEAK_HOLD_INDEX_EN
    logic [g_WINDOW_LOG2-1:0] idx_q;
    logic [g_WINDOW_LOG2-1:0] peak_index_q;
    logic [g_WINDOW_LOG2-1:0] idx_nxt_c;
`endif

    // Pair assembly and power pipeline next-state
    always_comb begin
        i_held_d    = i_held_q;
        i_data_d    = i_data_q;
        sync_err_d  = 1'b0;
        pair_fire_c = 1'b0;
        i_ext_c     = PW'(i_data_q);
        q_ext_c     = PW'($signed(s_axis_tdata));

        if (s_axis_tvalid) begin
            if (!s_axis_tlast) begin
                // A repeated I before its Q simply replaces the held sample
                i_held_d = 1'b1;
                i_data_d = $signed(s_axis_tdata);
            end else if (i_held_q) begin
                pair_fire_c = 1'b1;
                i_held_d    = 1'b0;
            end else begin
                sync_err_d = 1'b1;
            end
        end

        prod_vld_d = pair_fire_c;
        prod_ii_d  = prod_ii_q;
        prod_qq_d  = prod_qq_q;
        if (pair_fire_c) begin
            prod_ii_d = PW'(i_ext_c * i_ext_c);
            prod_qq_d = PW'(q_ext_c * q_ext_c);
        end

        pwr_vld_d = prod_vld_q;
        pwr_d     = pwr_q;
        if (prod_vld_q) begin
            // Max is 2*(2^(DW-1))^2 = 2^(PW-1), so the unsigned sum cannot overflow
            pwr_d = prod_ii_q + prod_qq_q;
        end
    end

    // Running-peak candidate for the power currently leaving the pipeline
    always_comb begin
        cnt_inc_c  = cnt_q + CW'(1);
        new_peak_c = (pwr_q > peak_q);
        peak_nxt_c = new_peak_c ? pwr_q : peak_q;
`ifdef IQ_PEAK_HOLD_INDEX_EN
        idx_nxt_c  = new_peak_c ? cnt_q[g_WINDOW_LOG2-1:0] : idx_q;
`endif
    end

    // Passthrough, pair assembly and power pipeline registers
    always_ff @(posedge aclk) begin
        if (areset) begin
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            i_held_q   <= 1'b0;
            i_data_q   <= '0;
            sync_err_q <= 1'b0;
            prod_vld_q <= 1'b0;
            prod_ii_q  <= '0;
            prod_qq_q  <= '0;
            pwr_vld_q  <= 1'b0;
            pwr_q      <= '0;
        end else begin
            m_tdata_q  <= s_axis_tdata;
            m_tvalid_q <= s_axis_tvalid;
            m_tlast_q  <= s_axis_tlast;
            i_held_q   <= i_held_d;
            i_data_q   <= i_data_d;
            sync_err_q <= sync_err_d;
            prod_vld_q <= prod_vld_d;
            prod_ii_q  <= prod_ii_d;
            prod_qq_q  <= prod_qq_d;
            pwr_vld_q  <= pwr_vld_d;
            pwr_q      <= pwr_d;
        end
    end

    // Measurement FSM with registered report outputs
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            peak_q       <= '0;
            peak_power_q <= '0;
            peak_valid_q <= 1'b0;
`ifdef IQ_PEAK_HOLD_INDEX_EN
            idx_q        <= '0;
            peak_index_q <= '0;
`endif
        end else begin
            peak_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_trigger) begin
                        state_q <= ST_MEASURE;
                        cnt_q   <= '0;
                        peak_q  <= '0;
`ifdef IQ_PEAK_HOLD_INDEX_EN
                        idx_q   <= '0;
`endif
                    end
                end
                ST_MEASURE: begin
                    // Dropping the trigger abandons the window, even on its last pair
                    if (!i_trigger) begin
                        state_q <= ST_IDLE;
                    end else if (pwr_vld_q) begin
                        cnt_q  <= cnt_inc_c;
                        peak_q <= peak_nxt_c;
`ifdef IQ_PEAK_HOLD_INDEX_EN
                        idx_q  <= idx_nxt_c;
`endif
                        if (cnt_inc_c == WIN_PAIRS) begin
                            // Report is loaded here so it is visible during REPORT
                            state_q      <= ST_REPORT;
                            peak_power_q <= peak_nxt_c;
                            peak_valid_q <= 1'b1;
`ifdef IQ_PEAK_HOLD_INDEX_EN
                            peak_index_q <= idx_nxt_c;
`endif
                        end
                    end
                end
                ST_REPORT: begin
                    cnt_q   <= '0;
                    peak_q  <= '0;
`ifdef IQ_PEAK_HOLD_INDEX_EN
                    idx_q   <= '0;
`endif
                    state_q <= i_trigger ? ST_MEASURE : ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tlast  = m_tlast_q;
    assign o_peak_power  = peak_power_q;
    assign o_peak_valid  = peak_valid_q;
    assign o_sync_err    = sync_err_q;
`ifdef IQ_PEAK_HOLD_INDEX_EN
    assign o_peak_index  = peak_index_q;
`endif

endmodule

// File: tb/tb_iq_peak_hold.sv
// Directed testbench for iq_peak_hold (default parameters: 16-bit samples, 256-pair window).
// Index checks are active only when IQ_PEAK_HOLD_INDEX_EN is defined.
module tb_iq_peak_hold;

    logic        aclk          = 1'b0;
    logic        areset        = 1'b1;
    logic [15:0] s_axis_tdata  = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tlast  = 1'b0;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        i_trigger     = 1'b0;
    logic [31:0] o_peak_power;
    logic        o_peak_valid;
    logic        o_sync_err;
`ifdef IQ_PEAK_HOLD_INDEX_EN
    logic [7:0]  o_peak_index;
`endif

    iq_peak_hold dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .i_trigger     (i_trigger),
        .o_peak_power  (o_peak_power),
        .o_peak_valid  (o_peak_valid),
        .o_sync_err    (o_sync_err)
`ifdef IQ_PEAK_HOLD_INDEX_EN
        ,
        .o_peak_index  (o_peak_index)
`endif
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Monitor: passthrough reference, report capture and pulse counters
    logic [15:0] prev_d   = '0;
    logic        prev_v   = 1'b0;
    logic        prev_l   = 1'b0;
    logic        prev_rst = 1'b1;
    logic        mon_en   = 1'b0;
    int          pulse_cnt = 0;
    int          sync_cnt  = 0;
    logic [31:0] pow_log[$];
    int          idx_log[$];

    always @(negedge aclk) begin
        if (mon_en) begin
            check("m_axis", {m_axis_tlast, m_axis_tvalid, m_axis_tdata},
                  prev_rst ? 18'd0 : {prev_l, prev_v, prev_d});
        end
        prev_d   = s_axis_tdata;
        prev_v   = s_axis_tvalid;
        prev_l   = s_axis_tlast;
        prev_rst = areset;
        mon_en   = 1'b1;
        if (o_peak_valid) begin
            pulse_cnt++;
            pow_log.push_back(o_peak_power);
`ifdef IQ_PEAK_HOLD_INDEX_EN
            idx_log.push_back(int'(o_peak_index));
`else
            idx_log.push_back(0);
`endif
        end
        if (o_sync_err) sync_cnt++;
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic beat(input int d, input logic l);
        s_axis_tdata  = 16'(d);
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = l;
        tick();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic pair(input int i, input int q);
        beat(i, 1'b0);
        beat(q, 1'b1);
    endtask

    // Called right after the window's last Q beat: pulse must appear exactly 3 cycles after it
    task automatic wait_report(input string tag, input logic [31:0] pw, input int idx);
        tick();
        check({tag, "_early"}, o_peak_valid, 1'b0);
        tick();
        check({tag, "_valid"}, o_peak_valid, 1'b1);
        check({tag, "_power"}, o_peak_power, pw);
`ifdef IQ_PEAK_HOLD_INDEX_EN
        check({tag, "_index"}, o_peak_index, 8'(idx));
`else
        if (idx < 0) $display("negative index %0d", idx);
`endif
        tick();
        check({tag, "_pulse_end"}, o_peak_valid, 1'b0);
    endtask

    int base;

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_power", o_peak_power, 32'd0);
        check("rst_valid", o_peak_valid, 1'b0);
        check("rst_sync",  o_sync_err, 1'b0);
        areset = 1'b0;
        tick();
        check("post_rst_power", o_peak_power, 32'd0);
        check("post_rst_valid", o_peak_valid, 1'b0);

        // Constant window: all pairs 100,0
        i_trigger = 1'b1;
        tick();
        for (int k = 0; k < 256; k++) pair(100, 0);
        wait_report("const", 32'd10000, 0);

        // Full-scale negative pair in slot 37
        for (int k = 0; k < 256; k++) begin
            if (k == 37) pair(-32768, -32768);
            else         pair(0, 0);
        end
        wait_report("fullscale", 32'h8000_0000, 37);

        // Equal peaks at 10 and 20: earlier one is kept
        for (int k = 0; k < 256; k++) begin
            if (k == 10 || k == 20) pair(3, 4);
            else                    pair(0, 0);
        end
        wait_report("tie", 32'd25, 10);

        // Abort after pair 100, then re-arm
        base = pulse_cnt;
        for (int k = 0; k <= 100; k++) pair(50, 0);
        i_trigger = 1'b0;
        repeat (6) tick();
        check("abort_no_pulse", 64'(pulse_cnt - base), 64'd0);
        check("abort_power_kept", o_peak_power, 32'd25);
        i_trigger = 1'b1;
        tick();
        for (int k = 0; k < 256; k++) pair(7, 0);
        wait_report("rearm", 32'd49, 0);

        // Orphan Q beat: sync error once, not counted as a pair
        base = pulse_cnt;
        beat(5, 1'b1);
        check("sync_pulse", o_sync_err, 1'b1);
        tick();
        check("sync_pulse_end", o_sync_err, 1'b0);
        pair(1, 1);
        for (int k = 1; k < 256; k++) pair(0, 0);
        wait_report("sync_window", 32'd2, 0);
        check("sync_one_report", 64'(pulse_cnt - base), 64'd1);
        check("sync_count", 64'(sync_cnt), 64'd1);

        // Two back-to-back windows with trigger held
        base = pulse_cnt;
        for (int k = 0; k < 512; k++) begin
            if (k == 5)        pair(20, 0);
            else if (k == 506) pair(30, 0);
            else               pair(1, 1);
        end
        repeat (5) tick();
        check("b2b_pulses", 64'(pulse_cnt - base), 64'd2);
        if (pulse_cnt - base == 2) begin
            check("b2b_first",  pow_log[base],     32'd400);
            check("b2b_second", pow_log[base + 1], 32'd900);
`ifdef IQ_PEAK_HOLD_INDEX_EN
            check("b2b_first_idx",  64'(idx_log[base]),     64'd5);
            check("b2b_second_idx", 64'(idx_log[base + 1]), 64'd250);
`endif
        end

        // Reset mid-window discards it
        base = pulse_cnt;
        for (int k = 0; k < 50; k++) pair(9, 0);
        areset = 1'b1;
        tick();
        tick();
        check("midrst_power", o_peak_power, 32'd0);
        check("midrst_valid", o_peak_valid, 1'b0);
        areset = 1'b0;
        tick();
        for (int k = 0; k < 256; k++) pair(2, 0);
        wait_report("after_rst", 32'd4, 0);
        check("after_rst_one_report", 64'(pulse_cnt - base), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
